// File: rtl/uart_arinc_frame_sender.sv
// rtl/uart_arinc_frame_sender.sv - Host-side UART/ARINC row frame sender with per-byte ack handshake
module uart_arinc_frame_sender #(
  parameter int         WIGHT                 = 512,
  parameter int         NUM_BYTES             = 8'hC0,
  parameter logic [7:0] END_WORD              = 8'hDD,
  parameter logic [7:0] ANSWER_CODE           = 8'hAA,
  parameter logic [7:0] ANSWER_CODE_TAKE_ROW  = 8'hCC,
  parameter logic [7:0] SUCCESSFULLY_RECEIVED = 8'hBC,
  parameter logic [7:0] NOT_ALL_RECEIVED      = 8'h11,
  parameter int         ACK_TIMEOUT           = 2_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8:0]           row,
  input  logic [3*WIGHT-1:0]   payload,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid
);

  localparam int PW    = 3 * WIGHT;
  localparam int PB_W  = $clog2(PW);
  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;

  localparam logic [7:0]       LAST_IDX = 8'(NUM_BYTES + 2);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_ACK = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_REJECT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    FINISH
  } state_t;

  state_t state;
  state_t state_nxt;

  // Frame contents captured on the accepted start
  logic [8:0]       row_q;
  logic [PW-1:0]    payload_q;

  // Frame progress
  logic [7:0]       idx;
  logic [CNT_W-1:0] ack_cnt;
  logic [1:0]       err_q;
  logic [7:0]       tx_q;

  // Decisions made by the next-state logic and applied by the datapath
  logic             accept;
  logic             fire;
  logic             advance;
  logic             set_err;
  logic [1:0]       err_nxt;
  logic [7:0]       cur_byte;
  logic [7:0]       exp_ack;

  // Payload byte k goes out MSB-first on the wire side, so its bits are mirrored.
  function automatic logic [7:0] payload_byte(input logic [PW-1:0] data, input logic [7:0] k);
    logic [PB_W-1:0] base;
    logic [7:0]      rev;
    base = PB_W'({k, 3'b000});
    rev  = '0;
    for (int j = 0; j < 8; j++) begin
      rev[7-j] = data[base + PB_W'(j)];
    end
    return rev;
  endfunction

  // Byte that belongs to the current frame position
  always_comb begin
    if (idx == 8'd0) begin
      cur_byte = {7'd0, row_q[8]};
    end else if (idx == 8'd1) begin
      cur_byte = row_q[7:0];
    end else if (idx == LAST_IDX) begin
      cur_byte = END_WORD;
    end else begin
      cur_byte = payload_byte(payload_q, idx - 8'd2);
    end
  end

  // Ack expected for a non-final byte: row header bytes differ from payload bytes
  always_comb begin
    exp_ack = (idx < 8'd2) ? ANSWER_CODE_TAKE_ROW : ANSWER_CODE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-cycle datapath controls
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fire      = 1'b0;
    advance   = 1'b0;
    set_err   = 1'b0;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          fire      = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // An ack on the terminal-count cycle is still honoured.
        if (rx_valid) begin
          state_nxt = FINISH;
          if (idx == LAST_IDX) begin
            if (rx_data == NOT_ALL_RECEIVED) begin
              set_err = 1'b1;
              err_nxt = ERR_REJECT;
            end else if (rx_data != SUCCESSFULLY_RECEIVED) begin
              set_err = 1'b1;
              err_nxt = ERR_BAD_ACK;
            end
          end else if (rx_data == exp_ack) begin
            advance   = 1'b1;
            state_nxt = SEND;
          end else begin
            set_err = 1'b1;
            err_nxt = ERR_BAD_ACK;
          end
        end else if (ack_cnt >= CNT_TERM) begin
          set_err   = 1'b1;
          err_nxt   = ERR_TIMEOUT;
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame datapath: captured inputs, byte index, ack timer, abort cause, held tx byte
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q     <= '0;
      payload_q <= '0;
      idx       <= '0;
      ack_cnt   <= '0;
      err_q     <= ERR_NONE;
      tx_q      <= '0;
    end else begin
      if (accept) begin
        row_q     <= row;
        payload_q <= payload;
        idx       <= '0;
        err_q     <= ERR_NONE;
      end
      // The strobe cycle is cycle 0 of the ack window, so the first wait cycle sees 1.
      if (fire) begin
        tx_q    <= cur_byte;
        ack_cnt <= CNT_W'(1);
      end else if (state == WAIT_ACK && ack_cnt != CNT_MAX) begin
        ack_cnt <= ack_cnt + CNT_W'(1);
      end
      if (advance) begin
        idx <= idx + 8'd1;
      end
      if (set_err) begin
        err_q <= err_nxt;
      end
    end
  end

  // A reset cycle never launches a byte; the held copy keeps tx_data steady while the line is busy.
  always_comb begin
    tx_start = fire & ~rst;
    tx_data  = tx_start ? cur_byte : tx_q;
    busy     = (state == SEND) || (state == WAIT_ACK);
    done     = (state == FINISH) && (err_q == ERR_NONE);
    error    = (state == FINISH) && (err_q != ERR_NONE);
    err_code = err_q;
  end

endmodule

// File: tb/tb_uart_arinc_frame_sender.sv
// tb/tb_uart_arinc_frame_sender.sv - Randomized self-checking bench for uart_arinc_frame_sender
module tb_uart_arinc_frame_sender;

  localparam int WIGHT = 512;
  localparam int PW    = 3 * WIGHT;
  localparam int NB    = 192;
  localparam int LAST  = NB + 2;
  localparam int NTX   = NB + 3;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, tx_busy, rx_valid;
  logic [8:0]    row;
  logic [PW-1:0] payload;
  logic [7:0]    rx_data;

  logic       busy_a, done_a, error_a, tx_start_a, busy_b, done_b, error_b, tx_start_b;
  logic [1:0] err_code_a, err_code_b;
  logic [7:0] tx_data_a, tx_data_b;

  uart_arinc_frame_sender #(.WIGHT(WIGHT), .ACK_TIMEOUT(2_000_000)) dut_a (
    .clk(clk), .rst(rst), .start(start), .row(row), .payload(payload),
    .busy(busy_a), .done(done_a), .error(error_a), .err_code(err_code_a),
    .tx_data(tx_data_a), .tx_start(tx_start_a), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid));

  uart_arinc_frame_sender #(.WIGHT(WIGHT), .ACK_TIMEOUT(50)) dut_b (
    .clk(clk), .rst(rst), .start(start), .row(row), .payload(payload),
    .busy(busy_b), .done(done_b), .error(error_b), .err_code(err_code_b),
    .tx_data(tx_data_b), .tx_start(tx_start_b), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid));

  logic       sel;
  logic       busy_m, done_m, error_m, tx_start_m;
  logic [1:0] err_code_m;
  logic [7:0] tx_data_m;

  always_comb begin
    busy_m     = sel ? busy_b     : busy_a;
    done_m     = sel ? done_b     : done_a;
    error_m    = sel ? error_b    : error_a;
    tx_start_m = sel ? tx_start_b : tx_start_a;
    err_code_m = sel ? err_code_b : err_code_a;
    tx_data_m  = sel ? tx_data_b  : tx_data_a;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // peer configuration
  int         peer_delay, busy_len, wrong_idx, silent_idx;
  logic [7:0] wrong_val, final_code;
  bit         extra_en;

  // observation log
  int         cyc = 0;
  logic [7:0] tx_log[$];
  int         tx_cyc[$];
  int         done_cnt, err_cnt, err_cyc, stab_bad, s_cyc, n_tx;
  logic [1:0] err_seen;
  logic [7:0] last_tx, ack_byte;
  bit         ack_pend, extra_pend;
  int         ack_at, extra_at, busy_end;

  // Peer: models the transmitter busy window and the loader's answers; also records traffic.
  initial begin : peer_monitor
    ack_pend = 0; extra_pend = 0; busy_end = 0; rx_valid = 0; rx_data = 0; tx_busy = 0;
    done_cnt = 0; err_cnt = 0; stab_bad = 0; last_tx = 0; err_cyc = 0; err_seen = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      rx_valid = 1'b0;
      if (ack_pend && cyc == ack_at) begin
        rx_valid = 1'b1; rx_data = ack_byte; ack_pend = 0;
      end else if (extra_pend && cyc == extra_at) begin
        rx_valid = 1'b1; rx_data = 8'h40; extra_pend = 0;
      end
      tx_busy = (cyc < busy_end);
      @(negedge clk);
      if (tx_busy && !tx_start_m && tx_data_m !== last_tx) stab_bad++;
      if (tx_start_m) begin
        n_tx = tx_log.size();
        if (n_tx != silent_idx) begin
          ack_pend = 1; ack_at = cyc + peer_delay;
          if (n_tx == wrong_idx)  ack_byte = wrong_val;
          else if (n_tx < 2)      ack_byte = 8'hCC;
          else if (n_tx < LAST)   ack_byte = 8'hAA;
          else begin
            ack_byte = final_code;
            if (extra_en) begin extra_pend = 1; extra_at = ack_at + 3; end
          end
        end
        busy_end = cyc + 1 + busy_len;
        last_tx  = tx_data_m;
        tx_log.push_back(tx_data_m);
        tx_cyc.push_back(cyc);
      end
      if (done_m) done_cnt++;
      if (error_m) begin err_cnt++; err_cyc = cyc; err_seen = err_code_m; end
    end
  end

  // Reference: frame byte n for a given row/payload.
  function automatic logic [7:0] model_byte(input int n, input logic [8:0] r, input logic [PW-1:0] p);
    logic [7:0] b, rv;
    if (n == 0) return {7'd0, r[8]};
    if (n == 1) return r[7:0];
    if (n == LAST) return 8'hDD;
    b  = p[(n-2)*8 +: 8];
    rv = 8'd0;
    for (int j = 0; j < 8; j++) rv = {rv[6:0], b[j]};
    return rv;
  endfunction

  function automatic logic [PW-1:0] rnd_payload();
    logic [PW-1:0] p;
    for (int i = 0; i < PW/32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    tx_log.delete(); tx_cyc.delete();
    done_cnt = 0; err_cnt = 0; stab_bad = 0;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1; start = 1'b0;
    tick(); tick(); rst = 1'b0;
  endtask

  task automatic set_peer(input int dly, input int bl);
    peer_delay = dly; busy_len = bl; wrong_idx = -1; wrong_val = 8'h00;
    silent_idx = -1; final_code = 8'hBC; extra_en = 0;
  endtask

  task automatic launch(input logic [8:0] r, input logic [PW-1:0] p);
    tick(); row = r; payload = p; start = 1'b1;
    @(negedge clk); s_cyc = cyc;
    tick(); start = 1'b0; row = ~r; payload = ~p;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt + err_cnt > 0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    sel = 0;
    do_reset();
    @(negedge clk);
    n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy_m); end
    n_checks++; if (done_m !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done_m); end
    n_checks++; if (error_m !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b expected 0", error_m); end
    n_checks++; if (tx_start_m !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b expected 0", tx_start_m); end
    n_checks++; if (err_code_m !== 2'd0) begin n_fail++; $display("FAIL rst_err_code: got %0d expected 0", err_code_m); end
    n_checks++; if (tx_data_m !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h expected 00", tx_data_m); end
  endtask

  task automatic test_nominal();
    logic [8:0] r; logic [PW-1:0] p; bit ok;
    sel = 0; set_peer(100, 10);
    do_reset(); clear_logs();
    r = 9'h1A5; p = rnd_payload(); p[7:0] = 8'h01; p[PW-1 -: 8] = 8'h80;
    launch(r, p);
    wait_end(25000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL nom_end: no done/error within budget"); end
    @(negedge clk);
    n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL nom_busy: got %b expected 0", busy_m); end
    n_checks++; if (tx_log.size() != NTX) begin n_fail++; $display("FAIL nom_count: got %0d expected %0d", tx_log.size(), NTX); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL nom_done: got %0d expected 1", done_cnt); end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL nom_error: got %0d expected 0", err_cnt); end
    n_checks++; if (tx_cyc[0] != s_cyc + 1) begin n_fail++; $display("FAIL nom_latency: got %0d expected %0d", tx_cyc[0], s_cyc + 1); end
    n_checks++; if (tx_log[0] !== 8'h01) begin n_fail++; $display("FAIL nom_b0: got %h expected 01", tx_log[0]); end
    n_checks++; if (tx_log[1] !== 8'hA5) begin n_fail++; $display("FAIL nom_b1: got %h expected a5", tx_log[1]); end
    n_checks++; if (tx_log[2] !== 8'h80) begin n_fail++; $display("FAIL nom_b2: got %h expected 80", tx_log[2]); end
    n_checks++; if (tx_log[193] !== 8'h01) begin n_fail++; $display("FAIL nom_b193: got %h expected 01", tx_log[193]); end
    n_checks++; if (tx_log[194] !== 8'hDD) begin n_fail++; $display("FAIL nom_b194: got %h expected dd", tx_log[194]); end
    for (int i = 0; i < tx_log.size(); i++) begin
      n_checks++;
      if (tx_log[i] !== model_byte(i, r, p)) begin
        n_fail++; $display("FAIL nom_byte[%0d]: got %h expected %h", i, tx_log[i], model_byte(i, r, p));
      end
    end
  endtask

  task automatic test_wrong_ack();
    logic [8:0] r; logic [PW-1:0] p; bit ok;
    sel = 0; set_peer(12, 5); wrong_idx = 1; wrong_val = 8'hAB;
    do_reset(); clear_logs();
    r = 9'($urandom); p = rnd_payload();
    launch(r, p);
    wait_end(2000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrong_end: no done/error within budget"); end
    repeat (30) tick();
    @(negedge clk); #1;
    n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL wrong_error: got %0d expected 1", err_cnt); end
    n_checks++; if (err_seen !== 2'd1) begin n_fail++; $display("FAIL wrong_code: got %0d expected 1", err_seen); end
    n_checks++; if (err_code_m !== 2'd1) begin n_fail++; $display("FAIL wrong_code_held: got %0d expected 1", err_code_m); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL wrong_done: got %0d expected 0", done_cnt); end
    n_checks++; if (tx_log.size() != 2) begin n_fail++; $display("FAIL wrong_count: got %0d expected 2", tx_log.size()); end
    n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL wrong_busy: got %b expected 0", busy_m); end
    n_checks++; if (tx_log[1] !== model_byte(1, r, p)) begin n_fail++; $display("FAIL wrong_b1: got %h expected %h", tx_log[1], model_byte(1, r, p)); end
  endtask

  task automatic test_timeout();
    bit ok;
    sel = 1; set_peer(10, 5); silent_idx = 5;
    do_reset(); clear_logs();
    launch(9'($urandom), rnd_payload());
    wait_end(2000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL to_end: no done/error within budget"); end
    repeat (100) tick();
    @(negedge clk); #1;
    n_checks++; if (err_seen !== 2'd2) begin n_fail++; $display("FAIL to_code: got %0d expected 2", err_seen); end
    n_checks++; if (err_cyc != tx_cyc[5] + 50) begin n_fail++; $display("FAIL to_cycle: got %0d expected %0d", err_cyc, tx_cyc[5] + 50); end
    n_checks++; if (tx_log.size() != 6) begin n_fail++; $display("FAIL to_count: got %0d expected 6", tx_log.size()); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL to_done: got %0d expected 0", done_cnt); end
    n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b expected 0", busy_m); end
  endtask

  task automatic test_ack_at_terminal();
    bit ok;
    sel = 1; set_peer(49, 5);
    do_reset(); clear_logs();
    launch(9'($urandom), rnd_payload());
    wait_end(12000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL term_end: no done/error within budget"); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL term_done: got %0d expected 1", done_cnt); end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL term_error: got %0d expected 0", err_cnt); end
    n_checks++; if (tx_log.size() != NTX) begin n_fail++; $display("FAIL term_count: got %0d expected %0d", tx_log.size(), NTX); end
  endtask

  task automatic test_reject();
    logic [8:0] r; logic [PW-1:0] p; bit ok;
    sel = 0; set_peer(12, 6); final_code = 8'h11; extra_en = 1;
    do_reset(); clear_logs();
    launch(9'($urandom), rnd_payload());
    wait_end(5000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rej_end: no done/error within budget"); end
    repeat (30) tick();
    @(negedge clk); #1;
    n_checks++; if (err_seen !== 2'd3) begin n_fail++; $display("FAIL rej_code: got %0d expected 3", err_seen); end
    n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL rej_error: got %0d expected 1", err_cnt); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL rej_done: got %0d expected 0", done_cnt); end
    n_checks++; if (tx_log.size() != NTX) begin n_fail++; $display("FAIL rej_count: got %0d expected %0d", tx_log.size(), NTX); end
    n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL rej_busy: got %b expected 0", busy_m); end
    set_peer(12, 6); clear_logs();
    r = 9'($urandom); p = rnd_payload();
    launch(r, p);
    wait_end(5000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rej2_end: no done/error within budget"); end
    @(negedge clk);
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rej2_done: got %0d expected 1", done_cnt); end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL rej2_error: got %0d expected 0", err_cnt); end
    n_checks++; if (err_code_m !== 2'd0) begin n_fail++; $display("FAIL rej2_code: got %0d expected 0", err_code_m); end
    for (int i = 0; i < tx_log.size(); i++) begin
      n_checks++;
      if (tx_log[i] !== model_byte(i, r, p)) begin
        n_fail++; $display("FAIL rej2_byte[%0d]: got %h expected %h", i, tx_log[i], model_byte(i, r, p));
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    sel = 0; set_peer(10, 30);
    do_reset(); clear_logs();
    launch(9'($urandom), rnd_payload());
    wait_end(8000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_end: no done/error within budget"); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done: got %0d expected 1", done_cnt); end
    n_checks++; if (tx_log.size() != NTX) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", tx_log.size(), NTX); end
    n_checks++; if (stab_bad != 0) begin n_fail++; $display("FAIL bp_tx_data_stable: got %0d changes expected 0", stab_bad); end
    for (int i = 1; i < tx_cyc.size(); i++) begin
      n_checks++;
      if (tx_cyc[i] - tx_cyc[i-1] != 31) begin
        n_fail++; $display("FAIL bp_gap[%0d]: got %0d expected 31", i, tx_cyc[i] - tx_cyc[i-1]);
      end
    end
  endtask

  task automatic test_reset_start();
    logic [8:0] r; logic [PW-1:0] p; bit ok;
    sel = 0; set_peer(20, 8);
    do_reset(); clear_logs();
    r = 9'($urandom); p = rnd_payload();
    launch(r, p);
    tick(); row = 9'($urandom); payload = rnd_payload(); start = 1'b1;
    @(negedge clk);
    n_checks++; if (busy_m !== 1'b1) begin n_fail++; $display("FAIL rs_busy_mid: got %b expected 1", busy_m); end
    tick(); start = 1'b0;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (tx_log.size() >= 13) begin ok = 1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rs_reach: byte 12 not sent within budget"); end
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL rs_busy: got %b expected 0", busy_m); end
    n_checks++; if (done_m !== 1'b0) begin n_fail++; $display("FAIL rs_done: got %b expected 0", done_m); end
    n_checks++; if (error_m !== 1'b0) begin n_fail++; $display("FAIL rs_error: got %b expected 0", error_m); end
    n_checks++; if (tx_start_m !== 1'b0) begin n_fail++; $display("FAIL rs_tx_start: got %b expected 0", tx_start_m); end
    n_checks++; if (err_code_m !== 2'd0) begin n_fail++; $display("FAIL rs_err_code: got %0d expected 0", err_code_m); end
    n_checks++; if (tx_data_m !== 8'h00) begin n_fail++; $display("FAIL rs_tx_data: got %h expected 00", tx_data_m); end
    for (int i = 0; i < 13; i++) begin
      n_checks++;
      if (tx_log[i] !== model_byte(i, r, p)) begin
        n_fail++; $display("FAIL rs_byte[%0d]: got %h expected %h", i, tx_log[i], model_byte(i, r, p));
      end
    end
    repeat (60) tick();
    @(negedge clk); #1;
    n_checks++; if (tx_log.size() != 13) begin n_fail++; $display("FAIL rs_no_tx: got %0d expected 13", tx_log.size()); end
    n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL rs_idle_busy: got %b expected 0", busy_m); end
    n_checks++; if (done_cnt + err_cnt != 0) begin n_fail++; $display("FAIL rs_no_pulse: got %0d expected 0", done_cnt + err_cnt); end
    clear_logs();
    r = 9'($urandom); r[8] = 1'b1; p = rnd_payload();
    launch(r, p);
    wait_end(8000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rs2_end: no done/error within budget"); end
    n_checks++; if (tx_log[0] !== 8'h01) begin n_fail++; $display("FAIL rs2_b0: got %h expected 01", tx_log[0]); end
    n_checks++; if (tx_cyc[0] != s_cyc + 1) begin n_fail++; $display("FAIL rs2_latency: got %0d expected %0d", tx_cyc[0], s_cyc + 1); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rs2_done: got %0d expected 1", done_cnt); end
    n_checks++; if (tx_log.size() != NTX) begin n_fail++; $display("FAIL rs2_count: got %0d expected %0d", tx_log.size(), NTX); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; row = '0; payload = '0; sel = 1'b0;
    set_peer(10, 5);
    test_reset();
    test_nominal();
    test_wrong_ack();
    test_timeout();
    test_ack_at_terminal();
    test_reject();
    test_backpressure();
    test_reset_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
